// File: rtl/v850_fetch_ctrl.sv
// V850 instruction-fetch sequencer: word fetches into a 4-halfword queue,
// 16/32-bit instruction assembly, and redirect flush with in-flight discard.
module v850_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is32
);

  localparam int unsigned HW_W  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  // IDLE: nothing pending; REQ: request driven; WAIT: accepted, data kept;
  // DISC: accepted before a redirect, data will be dropped on return.
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DISC} fetch_state_e;

  fetch_state_e                state_q, state_d;
  logic [DEPTH-1:0][HW_W-1:0]  q_q, q_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        drop_q, drop_d;
  logic [31:0]                 addr_d, pc_d;
  logic [1:0]                  pop_n, push_n;
  logic [1:0]                  base;
  logic [HW_W-1:0]             push_lo, push_hi;
  logic                        accept, push_en;
  logic                        head32_d, valid_d;
  logic [31:0]                 instr_d;

  // Next-state, queue update and next output values
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    addr_d   = imem_addr;
    pc_d     = instr_pc;
    pop_n    = 2'd0;
    push_n   = 2'd0;
    push_lo  = imem_rdata[15:0];
    push_hi  = imem_rdata[31:16];
    head32_d = 1'b0;
    valid_d  = 1'b0;
    instr_d  = '0;

    // A transfer coinciding with a redirect is void
    accept  = instr_valid && instr_ready && !redirect;
    push_en = (state_q == F_WAIT) && imem_rvalid && !redirect;

    if (accept) begin
      pop_n = instr_is32 ? 2'd2 : 2'd1;
      pc_d  = instr_pc + (instr_is32 ? 32'd4 : 32'd2);
    end

    if (push_en) begin
      if (drop_q) begin
        push_n  = 2'd1;
        push_lo = imem_rdata[31:16];
        drop_d  = 1'b0;
      end else begin
        push_n = 2'd2;
      end
    end

    case (pop_n)
      2'd1:    q_d = {q_q[3], q_q[3], q_q[2], q_q[1]};
      2'd2:    q_d = {q_q[3], q_q[2], q_q[3], q_q[2]};
      default: q_d = q_q;
    endcase

    // Issue only with two free slots, so a push always fits after any pops
    base = 2'(cnt_q - CNT_W'(pop_n));
    if (push_n != 2'd0) q_d[base] = push_lo;
    if (push_n == 2'd2) q_d[base + 2'd1] = push_hi;
    cnt_d = cnt_q - CNT_W'(pop_n) + CNT_W'(push_n);

    case (state_q)
      F_IDLE: if (cnt_d <= 3'd2) state_d = F_REQ;
      F_REQ: begin
        if (imem_gnt) begin
          state_d = F_WAIT;
          addr_d  = imem_addr + 32'd4;
        end
      end
      F_WAIT, F_DISC: begin
        if (imem_rvalid) state_d = (cnt_d <= 3'd2) ? F_REQ : F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase

    if (redirect) begin
      cnt_d  = '0;
      drop_d = redirect_pc[1];
      pc_d   = {redirect_pc[31:1], 1'b0};
      addr_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        F_REQ:          state_d = imem_gnt ? F_DISC : F_IDLE;
        F_WAIT, F_DISC: state_d = imem_rvalid ? F_IDLE : F_DISC;
        default:        state_d = F_IDLE;
      endcase
    end

    head32_d = (cnt_d != 3'd0) && (q_d[0][10:9] == 2'b11);
    valid_d  = (cnt_d >= 3'd1) && (!head32_d || (cnt_d >= 3'd2));
    if (cnt_d != 3'd0) instr_d[15:0] = q_d[0];
    if (head32_d && (cnt_d >= 3'd2)) instr_d[31:16] = q_d[1];
  end

  // Fetch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= F_IDLE;
    else        state_q <= state_d;
  end

  // Queue, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      cnt_q       <= '0;
      drop_q      <= RESET_PC[1];
      imem_req    <= 1'b0;
      imem_addr   <= {RESET_PC[31:2], 2'b00};
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= {RESET_PC[31:1], 1'b0};
      instr_is32  <= 1'b0;
    end else begin
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      imem_req    <= (state_d == F_REQ);
      imem_addr   <= addr_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      instr_pc    <= pc_d;
      instr_is32  <= head32_d;
    end
  end

endmodule

// File: tb/tb_v850_fetch_ctrl.sv
// Self-checking bench for v850_fetch_ctrl: directed vector table, multi-cycle
// corner sequences, and random traffic against an instruction-stream model.
module tb_v850_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is32;

  v850_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_is32(instr_is32)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at t=%0t", name, got, exp, $time);
  endtask

  // Memory contents: explicit overrides, otherwise an address hash
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_ovr.exists(wa)) return mem_ovr[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Memory model knobs
  bit gnt_en  = 1'b1;
  int gnt_pct = 100;
  int lat_min = 0;
  int lat_max = 0;

  logic        pend_v = 1'b0;
  logic [31:0] pend_a;
  int          pend_d;
  logic        m_req = 1'b0;
  logic [31:0] m_addr;

  // Memory: single-slot response model, driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_v = 1'b0; m_req = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    end else begin
      if (imem_rvalid) pend_v = 1'b0;
      if (m_req && imem_gnt) begin
        check("one_outstanding", 96'(pend_v), 96'(0));
        pend_v = 1'b1;
        pend_a = m_addr;
        pend_d = int'($urandom_range(lat_max, lat_min));
      end
      imem_rvalid = 1'b0;
      if (pend_v) begin
        if (pend_d == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_a);
        end else begin
          pend_d--;
        end
      end
      imem_gnt = gnt_en && (int'($urandom_range(99, 0)) < gnt_pct);
      m_req  = imem_req;
      m_addr = imem_addr;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        is32;
  } xfer_t;

  xfer_t       obs_q[$];
  logic [31:0] model_pc = RPC;
  logic [15:0] sb_h0;
  logic        sb_e32;
  logic [31:0] sb_ins;
  logic        p_ok = 1'b0, p_req, p_gnt, p_redir, p_valid, p_ready;
  logic [31:0] p_addr, p_instr, p_pc;

  // Scoreboard: instruction stream model plus handshake stability rules
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      model_pc = {RPC[31:1], 1'b0};
      p_ok = 1'b0;
    end else begin
      if (imem_req) check("addr_align", 96'(imem_addr[1:0]), 96'(0));
      if (p_ok && p_req && !p_gnt && !p_redir)
        check("req_hold", 96'({imem_req, imem_addr}), 96'({1'b1, p_addr}));
      if (p_ok && p_valid && !p_ready && !p_redir)
        check("instr_hold", 96'({instr_valid, instr_pc, instr}), 96'({1'b1, p_pc, p_instr}));
      if (redirect) begin
        model_pc = {redirect_pc[31:1], 1'b0};
      end else if (instr_valid && instr_ready) begin
        obs_q.push_back('{instr_pc, instr, instr_is32});
        sb_h0  = hw(model_pc);
        sb_e32 = (sb_h0[10:9] == 2'b11);
        sb_ins = sb_e32 ? {hw(model_pc + 32'd2), sb_h0} : {16'h0000, sb_h0};
        check("xfer", 96'({instr_is32, instr_pc, instr}), 96'({sb_e32, model_pc, sb_ins}));
        model_pc = model_pc + (sb_e32 ? 32'd4 : 32'd2);
      end
      p_ok = 1'b1; p_req = imem_req; p_addr = imem_addr; p_gnt = imem_gnt;
      p_redir = redirect; p_valid = instr_valid; p_ready = instr_ready;
      p_instr = instr; p_pc = instr_pc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    #3;
    rst_n = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    tick(2);
    obs_q.delete();
    mem_ovr.delete();
  endtask

  task automatic reset_release();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    #3;
    check(name, 96'(obs_q.size() >= n), 96'(1));
  endtask

  task automatic load_stream16();
    for (int i = 0; i < 8; i++)
      mem_ovr[32'(i * 4)] = {16'h01C0 + 16'(2 * i + 2), 16'h01C0 + 16'(2 * i + 1)};
  endtask

  typedef struct {
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic [2:0][31:0] pc;
    logic [2:0][31:0] ins;
    logic [2:0]       is32;
  } vec_t;

  vec_t        vecs[3];
  logic [31:0] a0;
  int          n0;
  int          c;

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Reset state
    #2;
    check("rst_req_addr", 96'({imem_req, imem_addr}), 96'({1'b0, RPC[31:2], 2'b00}));
    check("rst_instr", 96'({instr_valid, instr_is32, instr_pc, instr}),
          96'({1'b0, 1'b0, RPC[31:1], 1'b0, 32'h0}));

    // Directed vectors: two memory words after reset, first three instructions
    vecs[0] = '{32'h01C2_01C1, 32'h01C4_01C3, {32'd4, 32'd2, 32'd0},
                {32'h0000_01C3, 32'h0000_01C2, 32'h0000_01C1}, 3'b000};
    vecs[1] = '{32'h0620_01C0, 32'h01C0_1234, {32'd6, 32'd2, 32'd0},
                {32'h0000_01C0, 32'h1234_0620, 32'h0000_01C0}, 3'b010};
    vecs[2] = '{32'h0600_0580, 32'h0000_ABCD, {32'd6, 32'd2, 32'd0},
                {32'h0000_0000, 32'hABCD_0600, 32'h0000_0580}, 3'b010};

    for (int v = 0; v < 3; v++) begin
      reset_assert();
      gnt_en = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 2;
      mem_ovr[32'h0] = vecs[v].w0;
      mem_ovr[32'h4] = vecs[v].w1;
      reset_release();
      @(negedge clk);
      check($sformatf("vec%0d_first_req", v), 96'({imem_req, imem_addr}), 96'({1'b1, 32'h0}));
      instr_ready = 1'b1;
      wait_xfers(3, 100, $sformatf("vec%0d_count", v));
      for (int k = 0; k < 3; k++)
        if (k < obs_q.size())
          check($sformatf("vec%0d_%0d", v, k),
                96'({obs_q[k].is32, obs_q[k].pc, obs_q[k].ins}),
                96'({vecs[v].is32[k], vecs[v].pc[k], vecs[v].ins[k]}));
    end

    // Backpressure: queue fills, fetch stops, head instruction holds
    reset_assert();
    load_stream16();
    gnt_pct = 100; lat_min = 0; lat_max = 2;
    reset_release();
    tick(20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_stall", 96'({imem_req, instr_valid, instr_pc, instr}),
            96'({1'b0, 1'b1, 32'h0, 32'h0000_01C1}));
    end
    instr_ready = 1'b1;
    wait_xfers(12, 200, "bp_drain_count");
    for (int k = 0; k < 12; k++)
      if (k < obs_q.size())
        check($sformatf("bp_order_%0d", k), 96'({obs_q[k].pc, obs_q[k].ins}),
              96'({32'(2 * k), 16'h0000, 16'h01C1 + 16'(k)}));

    // Async reset with three halfwords queued
    reset_assert();
    load_stream16();
    reset_release();
    tick(20);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    tick(2);
    check("q3_before_rst", 96'({imem_req, instr_valid, instr_pc, instr}),
          96'({1'b0, 1'b1, 32'h2, 32'h0000_01C2}));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_fetch", 96'({imem_req, imem_addr}), 96'({1'b0, RPC[31:2], 2'b00}));
    check("async_rst_instr", 96'({instr_valid, instr_is32, instr_pc, instr}),
          96'({1'b0, 1'b0, RPC[31:1], 1'b0, 32'h0}));
    tick(2);
    obs_q.delete();
    reset_release();
    @(negedge clk);
    check("restart_req", 96'({imem_req, imem_addr}), 96'({1'b1, 32'h0}));
    instr_ready = 1'b1;
    wait_xfers(2, 100, "restart_count");
    if (obs_q.size() > 0) check("restart_pc", 96'(obs_q[0].pc), 96'(0));

    // Redirect while the fetch of 0x8 is outstanding
    reset_assert();
    load_stream16();
    mem_ovr[32'h100] = 32'h01C7_01C6;
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    reset_release();
    instr_ready = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (!(pend_v && pend_a == 32'h8) && c < 100);
    check("redir_found_0x8", 96'(pend_v && pend_a == 32'h8), 96'(1));
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    n0 = obs_q.size();
    @(negedge clk);
    redirect = 1'b0;
    c = 0;
    while (!imem_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    #1;
    check("redir_new_req", 96'({imem_req, imem_addr, pend_v}), 96'({1'b1, 32'h100, 1'b0}));
    wait_xfers(n0 + 1, 100, "redir_count");
    if (obs_q.size() > n0)
      check("redir_first", 96'({obs_q[n0].is32, obs_q[n0].pc, obs_q[n0].ins}),
            96'({1'b0, 32'h102, 32'h0000_01C7}));

    // Grant withheld; redirect in the third stalled cycle
    reset_assert();
    gnt_en = 1'b0; lat_min = 0; lat_max = 2;
    reset_release();
    instr_ready = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!imem_req && c < 10);
    a0 = imem_addr;
    check("nogrant_addr", 96'({imem_req, a0}), 96'({1'b1, 32'h0}));
    for (int cy = 1; cy <= 5; cy++) begin
      if (cy > 1) @(negedge clk);
      if (cy <= 3) check($sformatf("nogrant_hold%0d", cy), 96'({imem_req, imem_addr}), 96'({1'b1, a0}));
      if (cy == 3) begin redirect = 1'b1; redirect_pc = 32'h0000_0200; end
      if (cy == 4) begin redirect = 1'b0; check("nogrant_retract", 96'(imem_req), 96'(0)); end
      if (cy == 5) check("nogrant_reissue", 96'({imem_req, imem_addr}), 96'({1'b1, 32'h200}));
    end
    gnt_en = 1'b1;

    // Random traffic against the stream model
    reset_assert();
    gnt_en = 1'b1; gnt_pct = 60; lat_min = 0; lat_max = 3;
    reset_release();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      instr_ready = (int'($urandom_range(99, 0)) < 70);
      redirect    = (int'($urandom_range(99, 0)) < 3);
      if (redirect)
        redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                  : $urandom;
    end
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b0;
    check("random_progress", 96'(obs_q.size() >= 200), 96'(1));

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
